// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code receive path: step directions,
// queue depth, event layout and the classifier's verdict type.
package gray_pkg;

    // Step direction as carried in the event's direction bit.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Number of events the decoder can hold before it drops new ones.
    localparam int GSD_QUEUE_DEPTH = 2;

    // Event layout is {bin[N-1:0], up}; the direction bit sits at the LSB.
    localparam int GSD_EVT_UP_BIT = 0;

    // Verdict on one synchronised sample compared with the previous one.
    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN,
        STEP_JUMP
    } step_kind_e;

endpackage

// File: rtl/gray2bin_N.sv
// Combinational Gray-to-binary converter; inverse of bin2gray_N.
// Each binary bit is the XOR of the Gray bit at that position and every
// Gray bit above it.
module gray2bin_N #(
    parameter int N = 4
) (
    input  logic [N-1:0] gray_i,
    output logic [N-1:0] bin_o
);

    // Ripple the XOR from the MSB down, using a local accumulator.
    always_comb begin
        logic [N-1:0] acc;
        acc        = '0;
        acc[N-1]   = gray_i[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            acc[i] = acc[i+1] ^ gray_i[i];
        end
        bin_o = acc;
    end

endmodule

// File: rtl/gray_step_decoder.sv
// Receiver for a Gray-coded counter from a foreign clock domain.
// Synchronises the bus, converts it to binary, classifies each change as
// +1, -1 or an illegal jump, and queues legal steps in a 2-entry FIFO.
// N >= 2 and SYNC_STAGES >= 2 are assumed.
module gray_step_decoder
    import gray_pkg::*;
#(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] gray_in,
    output logic [N-1:0] cur_bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_bin,
    output logic         out_up,
    input  logic         err_clr,
    output logic         err_jump,
    output logic         err_ovf
);

    localparam logic [N-1:0] ONE  = N'(1);
    localparam logic [1:0]   FULL = 2'(GSD_QUEUE_DEPTH);

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [N-1:0]           sync_q [SYNC_STAGES];
    logic [N-1:0]           g_s;

    // Plain flop chain into the clk domain.
    // NOTE: every stage is reset; a stale value left in the chain would be
    // classified as a real transition once the block is primed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign g_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Conversion and classification
    // ------------------------------------------------------------------
    logic [N-1:0]           b;
    logic [N-1:0]           g_p_q, g_p_d;
    logic [N-1:0]           bin_p_q, bin_p_d;
    logic                   primed_q, primed_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic [N-1:0]           d;
    logic                   one_bit;
    step_kind_e             kind;

    gray2bin_N #(.N(N)) u_gray2bin (
        .gray_i (g_s),
        .bin_o  (b)
    );

    // Decide what the current synchronised sample means relative to g_p.
    always_comb begin
        d       = g_s ^ g_p_q;
        one_bit = (d != '0) && ((d & (d - ONE)) == '0);
        kind    = STEP_NONE;
        if (primed_q && (d != '0)) begin
            if (one_bit && (b == bin_p_q + ONE))      kind = STEP_UP;
            else if (one_bit && (b == bin_p_q - ONE)) kind = STEP_DOWN;
            else                                      kind = STEP_JUMP;
        end
    end

    // Reference-sample update. fill_q tracks when g_s holds a post-reset
    // sample, so priming keeps reloading until the chain has flushed and a
    // nonzero bus present at reset release is absorbed silently.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        g_p_d    = g_p_q;
        bin_p_d  = bin_p_q;
        primed_d = primed_q;
        fill_d   = {fill_q[SYNC_STAGES-2:0], 1'b1};
        if (!primed_q) begin
            g_p_d    = g_s;
            bin_p_d  = b;
            primed_d = fill_q[SYNC_STAGES-1];
        end else if (kind != STEP_NONE) begin
            g_p_d    = g_s;
            bin_p_d  = b;
        end
    end

    // ------------------------------------------------------------------
    // Event queue and error flags
    // ------------------------------------------------------------------
    logic [N:0]             ent_q [GSD_QUEUE_DEPTH];
    logic [N:0]             ent_d [GSD_QUEUE_DEPTH];
    logic [1:0]             cnt_q, cnt_d;
    logic [N:0]             new_evt;
    logic                   push, pop, accept, drop;
    logic                   err_jump_q, err_jump_d;
    logic                   err_ovf_q, err_ovf_d;

    assign push    = (kind == STEP_UP) || (kind == STEP_DOWN);
    assign pop     = (cnt_q != 2'd0) && out_ready;
    assign accept  = push && ((cnt_q != FULL) || pop);
    assign drop    = push && (cnt_q == FULL) && !pop;
    assign new_evt = {b, (kind == STEP_UP) ? DIR_UP : DIR_DOWN};

    // FIFO with the head always in entry 0; a pop shifts entry 1 forward.
    always_comb begin
        ent_d = ent_q;
        cnt_d = cnt_q;
        case ({pop, accept})
            2'b10: begin
                ent_d[0] = ent_q[1];
                cnt_d    = cnt_q - 2'd1;
            end
            2'b01: begin
                ent_d[cnt_q[0]] = new_evt;
                cnt_d           = cnt_q + 2'd1;
            end
            2'b11: begin
                if (cnt_q == FULL) begin
                    ent_d[0] = ent_q[1];
                    ent_d[1] = new_evt;
                end else begin
                    ent_d[0] = new_evt;
                end
            end
            default: ;
        endcase
    end

    // Sticky flags: a set condition overrides a simultaneous clear.
    always_comb begin
        err_jump_d = err_jump_q;
        err_ovf_d  = err_ovf_q;
        if (err_clr) begin
            err_jump_d = 1'b0;
            err_ovf_d  = 1'b0;
        end
        if (kind == STEP_JUMP) err_jump_d = 1'b1;
        if (drop)              err_ovf_d  = 1'b1;
    end

    // State register for the reference sample, queue and flags.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_p_q      <= '0;
            bin_p_q    <= '0;
            primed_q   <= 1'b0;
            fill_q     <= '0;
            cnt_q      <= 2'd0;
            err_jump_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            for (int i = 0; i < GSD_QUEUE_DEPTH; i++) ent_q[i] <= '0;
        end else begin
            g_p_q      <= g_p_d;
            bin_p_q    <= bin_p_d;
            primed_q   <= primed_d;
            fill_q     <= fill_d;
            cnt_q      <= cnt_d;
            err_jump_q <= err_jump_d;
            err_ovf_q  <= err_ovf_d;
            for (int i = 0; i < GSD_QUEUE_DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

    // All outputs come straight from registers.
    assign cur_bin   = bin_p_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_bin   = ent_q[0][N:1];
    assign out_up    = ent_q[0][GSD_EVT_UP_BIT];
    assign err_jump  = err_jump_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Directed self-checking bench for gray_step_decoder (N=4, SYNC_STAGES=2).
// Inputs change just after a falling edge; outputs are sampled on falling
// edges, away from the active rising edge.
module tb_gray_step_decoder;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] gray_in;
    logic [N-1:0] cur_bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_bin;
    logic         out_up;
    logic         err_clr;
    logic         err_jump;
    logic         err_ovf;

    int n_pass  = 0;
    int n_total = 0;
    int n_events = 0;

    gray_step_decoder #(.N(N), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .cur_bin   (cur_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_up    (out_up),
        .err_clr   (err_clr),
        .err_jump  (err_jump),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic [N-1:0] to_gray(input int v);
        logic [N-1:0] x;
        x = N'(v);
        return x ^ (x >> 1);
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset with a nonzero bus; priming must absorb it.
        rst_n     = 1'b0;
        gray_in   = 4'b0110;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        #12;
        check("rst_cur_bin",   32'(cur_bin),   0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_err_jump",  32'(err_jump),  0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(5);
        check("prime_cur_bin",   32'(cur_bin),   4);
        check("prime_out_valid", 32'(out_valid), 0);
        check("prime_err_jump",  32'(err_jump),  0);
        check("prime_err_ovf",   32'(err_ovf),   0);

        // Restart from zero for the up sweep.
        rst_n   = 1'b0;
        gray_in = '0;
        cycles(1);
        rst_n = 1'b1;
        cycles(4);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            gray_in = to_gray(i);
            cycles(2);
            check("sweep_early", 32'(out_valid), 0);
            cycles(1);
            if (out_valid) n_events++;
            check("sweep_valid", 32'(out_valid), 1);
            check("sweep_bin",   32'(out_bin),   32'(i % 16));
            check("sweep_up",    32'(out_up),    1);
            cycles(1);
        end
        check("sweep_events", 32'(n_events), 16);
        check("sweep_cur_bin", 32'(cur_bin), 0);
        check("sweep_err_jump", 32'(err_jump), 0);
        check("sweep_err_ovf",  32'(err_ovf),  0);

        // Climb to 5, then step down to 4.
        for (int i = 1; i <= 5; i++) begin
            gray_in = to_gray(i);
            cycles(4);
        end
        check("at5_cur_bin", 32'(cur_bin), 5);
        gray_in = to_gray(4);
        cycles(3);
        check("down_valid", 32'(out_valid), 1);
        check("down_bin",   32'(out_bin),   4);
        check("down_up",    32'(out_up),    0);
        cycles(1);

        // Two-bit change 0110 -> 0000 is illegal.
        gray_in = 4'b0000;
        cycles(3);
        check("jump_valid",   32'(out_valid), 0);
        check("jump_flag",    32'(err_jump),  1);
        check("jump_cur_bin", 32'(cur_bin),   0);
        cycles(1);
        pulse_clr();
        check("clr_err_jump", 32'(err_jump), 0);

        // Overflow: three up-steps with the consumer stalled.
        out_ready = 1'b0;
        gray_in = to_gray(1);
        cycles(4);
        check("ovf_q1_valid", 32'(out_valid), 1);
        check("ovf_q1_bin",   32'(out_bin),   1);
        gray_in = to_gray(2);
        cycles(4);
        check("ovf_q2_head", 32'(out_bin), 1);
        check("ovf_q2_flag", 32'(err_ovf), 0);
        gray_in = to_gray(3);
        cycles(4);
        check("ovf_flag",    32'(err_ovf), 1);
        check("ovf_cur_bin", 32'(cur_bin), 3);
        check("ovf_head",    32'(out_bin), 1);
        out_ready = 1'b1;
        cycles(1);
        check("drain_valid", 32'(out_valid), 1);
        check("drain_bin",   32'(out_bin),   2);
        cycles(1);
        check("drain_empty", 32'(out_valid), 0);
        out_ready = 1'b0;
        pulse_clr();
        check("clr_err_ovf", 32'(err_ovf), 0);

        // Fill the queue with 4, 5 then push 6 in the same cycle as a pop.
        gray_in = to_gray(4);
        cycles(4);
        gray_in = to_gray(5);
        cycles(4);
        check("full_head", 32'(out_bin), 4);
        gray_in = to_gray(6);
        cycles(2);
        out_ready = 1'b1;
        cycles(1);
        check("pp_err_ovf", 32'(err_ovf),   0);
        check("pp_valid",   32'(out_valid), 1);
        check("pp_head",    32'(out_bin),   5);
        cycles(1);
        check("pp_next",    32'(out_bin),   6);
        check("pp_next_up", 32'(out_up),    1);
        cycles(1);
        check("pp_empty",   32'(out_valid), 0);
        out_ready = 1'b0;

        // Jump from 0101 to 0000 with err_clr asserted in the same cycle.
        gray_in = 4'b0000;
        cycles(2);
        check("jc_before", 32'(err_jump), 0);
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        check("jc_flag",    32'(err_jump),  1);
        check("jc_cur_bin", 32'(cur_bin),   0);
        check("jc_valid",   32'(out_valid), 0);

        // Queue two events, overflow a third, then reset between edges.
        for (int i = 1; i <= 3; i++) begin
            gray_in = to_gray(i);
            cycles(4);
        end
        check("mid_valid", 32'(out_valid), 1);
        check("mid_ovf",   32'(err_ovf),   1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",    32'(out_valid), 0);
        check("arst_out_bin",  32'(out_bin),   0);
        check("arst_out_up",   32'(out_up),    0);
        check("arst_cur_bin",  32'(cur_bin),   0);
        check("arst_err_jump", 32'(err_jump),  0);
        check("arst_err_ovf",  32'(err_ovf),   0);
        cycles(2);
        rst_n = 1'b1;
        cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gray_step_decoder.md
# gray_step_decoder

Receiver stage for Gray-coded counter values that come from another clock domain, such as a remote position or pointer counter encoded by a parameterised binary-to-Gray encoder. The block synchronises the Gray bus into the `clk` domain and converts it to binary. It classifies each observed change as an up-step, a down-step or an illegal jump, and queues legal steps in a 2-entry valid/ready buffer. Sticky error flags report illegal input and dropped events.

## Interface
Parameters:
- `N`, 4: width of the Gray and binary buses; minimum 2.
- `SYNC_STAGES`, 2: synchroniser depth; minimum 2.

Ports:
- `clk`, input, 1: single clock; all state is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `gray_in`, input, N: Gray value from the foreign domain; asynchronous to `clk`.
- `cur_bin`, output, N: registered binary value of the last accepted sample.
- `out_valid`, output, 1: queue head is valid.
- `out_ready`, input, 1: consumer accepts the head.
- `out_bin`, output, N: binary value after the step at the queue head.
- `out_up`, output, 1: step direction at the head; 1 = +1, 0 = -1 (mod 2^N).
- `err_clr`, input, 1: one-cycle pulse that clears `err_jump` and `err_ovf`.
- `err_jump`, output, 1: sticky; an illegal Gray transition was seen.
- `err_ovf`, output, 1: sticky; a legal step was dropped because the queue was full.

## Operation
- **Synchroniser.** `gray_in` passes through a chain of `SYNC_STAGES` flops, all reset to 0. The last stage is `g_s`.
- **State.** `g_p` holds the previous sample (N bits), `bin_p` its binary value, and `primed` is a 1-bit flag.
- **Priming.**
  - While `primed`=0: at each edge, load `g_p`←`g_s` and `bin_p`←gray2bin(`g_s`), then set `primed`.
  - No event is pushed and no error is raised while priming.
  - This absorbs any nonzero `gray_in` present at reset release.
- **Classification.** With `primed`=1, let `d` = `g_s` XOR `g_p` and `b` = gray2bin(`g_s`):
  - popcount(`d`)=0: nothing happens.
  - popcount(`d`)=1 and `b`==`bin_p`+1 mod 2^N: up-step; push {`b`, 1}.
  - popcount(`d`)=1 and `b`==`bin_p`-1 mod 2^N: down-step; push {`b`, 0}.
  - Any other change (more than one bit, or one bit giving a non-adjacent value): set `err_jump`; push nothing.
  - On every case except popcount 0, update `g_p`←`g_s` and `bin_p`←`b`, so the block resynchronises after an error.
- **Output.** `cur_bin` = `bin_p`.
- **Queue.**
  - 2 entries, FIFO order.
  - The head drives `out_bin`/`out_up`.
  - A pop happens when `out_valid` && `out_ready`.
- **Push when full.** If the queue is full and no pop occurs in the same cycle, the event is dropped and `err_ovf` is set. `bin_p` still updates.
- **Push and pop together when full.** Both happen; the occupancy stays at 2.
- **Push when empty.** There is no bypass; `out_valid` rises on the edge after the push.
- **Error flags.** `err_clr` clears both flags. If a set condition and `err_clr` occur in the same cycle, set wins.
- **Reset** (async assert, any time): synchroniser, `g_p`, `bin_p`, `primed`, queue and flags all go to 0. `out_valid`=0, `out_bin`=0, `out_up`=0, `cur_bin`=0, `err_jump`=0, `err_ovf`=0. Reset mid-stream discards queued events.

## Timing
- `gray_in` stable before edge k: `g_s` reflects it after edge k+`SYNC_STAGES`-1.
- Push and `g_p` update occur at edge k+`SYNC_STAGES`.
- `out_valid` and `cur_bin` are visible after edge k+`SYNC_STAGES`; the latency is `SYNC_STAGES`+1 edges from the first sampling edge.
- Throughput is one event per cycle in, and one pop per cycle out.
- All outputs are registered; there is no combinational path from `out_ready` to `out_valid`.
- `gray_in` must change by at most one Gray step per `clk` period. Faster input shows up as `err_jump`, which is the intended detection.

## Structure
- The shared package `gray_pkg` holds:
  - `DIR_UP`=1'b1 and `DIR_DOWN`=1'b0.
  - `GSD_QUEUE_DEPTH`=2.
  - The event struct or packed layout {bin[N-1:0], up}.
- Sub-module `gray2bin_N` (parameter `N`, combinational): `bin[N-1]`=`gray[N-1]`, and `bin[i]`=`bin[i+1]` XOR `gray[i]`. It is the inverse of the existing `bin2gray_N` and is placed in the same directory.
- Synchroniser, classifier and queue are inline in `gray_step_decoder`.

## Test plan
- **Reset and priming.** Reset with `gray_in`=4'b0110, then release. Required: after priming, `cur_bin`=4'd4, with no `out_valid` and no errors.
- **Up sweep.** Drive Gray 0→15→0, one step every 4 cycles, with `out_ready`=1. Required: 16 events, each `out_up`=1, `out_bin`=1,2,…,15,0 (the wrap 15→0 counts as up), latency 3 edges.
- **Down step and illegal jump.** From binary 5, drive Gray of 4. Required: event {4, 0}. Then drive Gray 4'b0110→4'b0000. Required: `err_jump`=1, no event, `cur_bin`=0.
- **Overflow.** Hold `out_ready`=0 and apply 3 legal up-steps from 0. Required: queue holds 1 then 2, `err_ovf`=1, `cur_bin`=3. Release `out_ready`: pops in order 1, 2.
- **Simultaneous events.** Full queue, then a push together with a pop. Required: no overflow, order preserved. Fire `err_clr` in the same cycle as a new jump. Required: `err_jump` stays 1.
- **Reset mid-operation.** Assert `rst_n`=0 asynchronously with 2 events queued. Required: all outputs go to 0 immediately, without waiting for a clock edge.
